// File: rtl/decoder_3to8_pulse.sv
// Handshaked 3-to-8 decoder: each accepted code drives one one-hot strobe for PULSE_LEN
// cycles, then a GAP_LEN idle gap. Optional sticky decode history when DEC_HIST_EN is defined.
module decoder_3to8_pulse #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic [7:0] hist,
  input  logic       hist_clr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  // Only compared when GAP_LEN > 0; clamped so a zero gap does not wrap.
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dout_q, dout_d;
  logic             accept;
  logic [7:0]       din_onehot;

  assign din_ready  = en && (state_q == ST_IDLE);
  assign accept     = din_valid && din_ready;
  assign din_onehot = 8'd1 << din;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dout_d  = din_onehot;
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == PULSE_LAST) begin
          dout_d  = '0;
          cnt_d   = '0;
          state_d = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        dout_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_ACTIVE) && (cnt_q == PULSE_LAST);

`ifdef DEC_HIST_EN
  logic [7:0] hist_q, hist_d;

  // A clear coinciding with an accept keeps only the newly decoded line.
  always_comb begin
    hist_d = hist_q;
    if (accept) begin
      hist_d = hist_clr ? din_onehot : (hist_q | din_onehot);
    end else if (hist_clr) begin
      hist_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist = hist_q;
`else
  logic unused_hist_clr;
  assign unused_hist_clr = hist_clr;
  assign hist = 8'h00;
`endif

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Scoreboard bench for decoder_3to8_pulse: a timeline model predicts ready/busy/hist and
// queues expected strobes; an independent monitor checks every pulse the DUT emits.
module tb_decoder_3to8_pulse;

  localparam int PULSE = 4;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] din = 3'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic [7:0] hist;
  logic       hist_clr = 1'b0;

  decoder_3to8_pulse #(
    .PULSE_LEN(PULSE),
    .GAP_LEN  (GAP),
    .CNT_W    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout     (dout),
    .busy     (busy),
    .done     (done),
    .hist     (hist),
    .hist_clr (hist_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    int         acc_edge;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  int         next_ok = 0;
  logic [7:0] hist_m = 8'h00;
  logic [7:0] prev_dout = 8'h00;
  int         run_len = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model decides whether the upcoming edge accepts.
  task automatic step(input logic e, input logic v, input logic [2:0] d, input logic clr);
    int         up;
    logic       mready;
    logic [7:0] oh;
    @(negedge clk);
    en = e; din_valid = v; din = d; hist_clr = clr;
    #1;
    up     = edge_cnt + 1;
    mready = e && (up >= next_ok);
    chk("din_ready", din_ready, mready);
    chk("busy", busy, (up < next_ok));
    chk("hist", hist, hist_m);
    oh = 8'd1 << d;
    if (v && mready) begin
      exp_q.push_back('{code: d, acc_edge: up});
      next_ok = up + PULSE + GAP + 1;
      $display("accept code=%0d at edge %0d", d, up);
    end
`ifdef DEC_HIST_EN
    if (v && mready) hist_m = clr ? oh : (hist_m | oh);
    else if (clr)    hist_m = 8'h00;
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_ok = 0;
    hist_m  = 8'h00;
  endtask

  // Monitor: consumes expected strobes as the DUT produces them.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_dout = 8'h00;
      run_len   = 0;
    end else begin
      chk("onehot0", $onehot0(dout), 1);
      if (dout != 8'h00) begin
        if (prev_dout == 8'h00) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", dout, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_code", dout, (8'd1 << e.code));
            chk("pulse_start_edge", edge_cnt, e.acc_edge);
            $display("pulse dout=%02h code=%0d edge=%0d", dout, e.code, edge_cnt);
          end
          run_len = 1;
        end else begin
          chk("dout_hold", dout, prev_dout);
          run_len++;
        end
        chk("done", done, (run_len == PULSE));
      end else begin
        if (prev_dout != 8'h00) chk("pulse_len", run_len, PULSE);
        chk("done_idle", done, 0);
        run_len = 0;
      end
      prev_dout = dout;
    end
  end

  initial begin
    // Reset and idle state
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", din_ready, 1);
    chk("rst_hist", hist, 8'h00);

    // Single decode of 5
    step(1, 1, 3'd5, 0);
    repeat (8) step(1, 0, 3'd0, 0);

    // Back-to-back with valid held: 0 then 7
    step(1, 1, 3'd0, 0);
    repeat (10) step(1, 1, 3'd7, 0);
    repeat (4) step(1, 0, 3'd0, 0);

    // Enable gating, then en dropped mid-strobe
    repeat (10) step(0, 1, 3'd3, 0);
    step(1, 1, 3'd3, 0);
    repeat (10) step(0, 1, 3'd3, 0);

    // Asynchronous reset two cycles into a strobe of 3
    step(1, 1, 3'd3, 0);
    step(1, 0, 3'd0, 0);
    step(1, 0, 3'd0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_dout", dout, 8'h08);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 8'h00);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    din_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", din_ready, 1);
    chk("post_rst_dout", dout, 8'h00);

    // History: 2 then 6, then clear with simultaneous accept of 1
    step(1, 1, 3'd2, 0);
    repeat (7) step(1, 0, 3'd0, 0);
    step(1, 1, 3'd6, 0);
    repeat (7) step(1, 0, 3'd0, 0);
`ifdef DEC_HIST_EN
    chk("hist_2_6", hist, 8'h44);
`else
    chk("hist_tied", hist, 8'h00);
`endif
    step(1, 1, 3'd1, 1);
    step(1, 0, 3'd0, 0);
`ifdef DEC_HIST_EN
    chk("hist_clr_set", hist, 8'h02);
`else
    chk("hist_tied2", hist, 8'h00);
`endif
    repeat (6) step(1, 0, 3'd0, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end

    repeat (12) step(1, 0, 3'd0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_pulse.md
Name: decoder_3to8_pulse

Overview:
- Sequential 3-to-8 decoder paired with the 8-to-3 priority encoder. It carries an encoded line index back out to one-hot form.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot output line for a programmable number of cycles.
- Enforces a programmable idle gap before the next code is accepted.
- Sits on the return path of the priority encoder, converting serviced indices back into per-line strobes (acknowledge/clear pulses).

Parameters:
- PULSE_LEN, 4: cycles each one-hot strobe is held. Legal range 1..2^CNT_W-1.
- GAP_LEN, 1: dead cycles after a strobe before ready reasserts. Legal range 0..2^CNT_W-1.
- CNT_W, 4: width of the internal cycle counter. Must hold max(PULSE_LEN, GAP_LEN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  acceptance enable; 0 blocks new codes only
- din  input  3  encoded line index
- din_valid  input  1  din is valid this cycle
- din_ready  output  1  block can accept a code this cycle
- dout  output  8  registered one-hot strobe, bit din set
- busy  output  1  high in ACTIVE or GAP
- done  output  1  one-cycle pulse on the final strobe cycle
- hist  output  8  sticky record of decoded lines (optional feature)
- hist_clr  input  1  synchronous clear of hist (optional feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, dout=0, busy=0, done=0, hist=0.
  - Applies immediately, including mid-pulse; the strobe is truncated.
  - After release, the first accept is possible on the next rising edge.
- din_ready = en AND (state==IDLE). It is combinational from registered state and en, with no path from din_valid.
- Accept: rising edge where din_valid=1 AND din_ready=1. din is sampled on that edge; din is don't-care otherwise.
- States:
  - IDLE: dout=0, busy=0. On accept: dout <= 1<<din, counter <= 0, go to ACTIVE.
  - ACTIVE: dout holds the one-hot value, busy=1, din_ready=0.
    - counter increments each cycle.
    - When counter==PULSE_LEN-1: done=1 that cycle. Next edge: dout <= 0, then go to GAP (GAP_LEN>0, counter <= 0) or to IDLE (GAP_LEN==0).
  - GAP: dout=0, busy=1, din_ready=0.
    - When counter==GAP_LEN-1, go to IDLE next edge.
- Latency: dout is set in the cycle after the accepting edge. It stays high for exactly PULSE_LEN cycles.
- Minimum accept-to-accept spacing: PULSE_LEN+GAP_LEN+1 cycles.
- dout is always exactly zero-hot or one-hot; never more than one bit set.
- en deasserted during ACTIVE/GAP: the sequence completes normally. en only gates acceptance.
- din_valid held high with ready low: no effect. The code is taken when ready rises, if valid is still high.
- din changing while ACTIVE: ignored; the latched index is held.
- done and busy are registered-state derived; no glitching on dout.

Optional Feature:
- Macro: DEC_HIST_EN
- Defined:
  - Each accept ORs (1<<din) into hist on the accepting edge.
  - hist_clr=1 zeroes hist on the next edge.
  - Simultaneous hist_clr and accept: hist <= (1<<din), i.e. the set wins for the new bit and all others clear.
  - hist resets to 0.
- Undefined: hist tied to 8'h00, hist_clr ignored, no history register synthesized. Ports remain present.

Test Plan:
- Reset/idle: hold rst_n=0, then release with en=1 -> dout=8'h00, busy=0, done=0, din_ready=1.
- Single decode (PULSE_LEN=4, GAP_LEN=1): din=3'd5 accepted at edge T -> dout=8'h20 for edges T+1..T+4; done=1 in the 4th strobe cycle; dout=0 and din_ready=0 for 1 gap cycle; din_ready=1 at T+6.
- Back-to-back: din_valid held high with din=0 then 7 -> dout=8'h01 for 4 cycles, gap, then dout=8'h80. Accept spacing is exactly 6 cycles; dout never 8'h81.
- Enable gating: en=0 with din_valid=1, din=3 for 10 cycles -> din_ready=0, dout=0. Drop en mid-strobe -> strobe completes its full 4 cycles.
- Async reset mid-strobe: rst_n low two cycles into dout=8'h08 -> dout=0 immediately, without waiting for an edge; busy=0; state IDLE after release.
- DEC_HIST_EN: decode 2, then 6 -> hist=8'h44. hist_clr with simultaneous accept of din=1 -> hist=8'h02. Without the macro, hist stays 8'h00 throughout.
